// File: rtl/branch_resolve_pkg.sv
// Shared encodings and condition helpers for the execute-stage branch resolver.
package branch_resolve_pkg;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_BEQ  = 3'd1,
    BR_BNE  = 3'd2,
    BR_BLT  = 3'd3,
    BR_BGE  = 3'd4,
    BR_BGT  = 3'd5,
    BR_BLE  = 3'd6,
    BR_JMP  = 3'd7
  } br_op_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_EVAL     = 2'd1,
    ST_REDIRECT = 2'd2
  } state_e;

  // Exactly one of three bits set: odd parity rules out 0 and 2, and all-three is excluded.
  function automatic logic flags_onehot(input logic lt, input logic eq, input logic gt);
    return (lt ^ eq ^ gt) && !(lt && eq && gt);
  endfunction

  function automatic logic cond_eval(input br_op_e op, input logic lt, input logic eq,
                                     input logic gt);
    case (op)
      BR_BEQ:  return eq;
      BR_BNE:  return !eq;
      BR_BLT:  return lt;
      BR_BGE:  return gt | eq;
      BR_BGT:  return gt;
      BR_BLE:  return lt | eq;
      BR_JMP:  return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/branch_resolve_sat_counter.sv
// Up-counter that sticks at all-ones; a synchronous clear takes priority over an increment.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/branch_resolve.sv
// Resolves one branch per handshake from comparator flags, raises a held PC redirect
// for taken branches, and keeps saturating branch/taken statistics.
module branch_resolve
  import branch_resolve_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       br_op,
  input  logic [WIDTH-1:0] lt,
  input  logic [WIDTH-1:0] eq,
  input  logic [WIDTH-1:0] gt,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] offset,
  output logic             resolved_valid,
  output logic             taken,
  output logic             redirect_valid,
  output logic [WIDTH-1:0] redirect_pc,
  input  logic             redirect_ack,
  output logic             flag_err,
  input  logic             clear_stats,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] taken_count
);

  state_e           r_state;
  br_op_e           r_op;
  logic             r_lt, r_eq, r_gt;
  logic [WIDTH-1:0] r_target;
  logic [WIDTH-1:0] r_redir_pc;
  logic             r_resolved, r_taken, r_redir_valid, r_flag_err;

  logic w_eval, w_malformed, w_cond, w_unused;

  // Only bit 0 of each comparator word carries information.
  assign w_unused = ^{lt[WIDTH-1:1], eq[WIDTH-1:1], gt[WIDTH-1:1]};

  assign w_eval      = (r_state == ST_EVAL);
  assign w_malformed = !flags_onehot(r_lt, r_eq, r_gt) && (r_op != BR_JMP) && (r_op != BR_NONE);
  assign w_cond      = cond_eval(r_op, r_lt, r_eq, r_gt) && !w_malformed;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_op          <= BR_NONE;
      r_lt          <= 1'b0;
      r_eq          <= 1'b0;
      r_gt          <= 1'b0;
      r_target      <= '0;
      r_redir_pc    <= '0;
      r_resolved    <= 1'b0;
      r_taken       <= 1'b0;
      r_redir_valid <= 1'b0;
    end else begin
      r_resolved <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_op     <= br_op_e'(br_op);
            r_lt     <= lt[0];
            r_eq     <= eq[0];
            r_gt     <= gt[0];
            r_target <= pc + offset;
            r_state  <= ST_EVAL;
          end
        end
        ST_EVAL: begin
          r_resolved <= 1'b1;
          r_taken    <= w_cond;
          if (w_cond) begin
            r_redir_valid <= 1'b1;
            r_redir_pc    <= r_target;
            r_state       <= ST_REDIRECT;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_REDIRECT: begin
          if (redirect_ack) begin
            r_redir_valid <= 1'b0;
            r_state       <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_flag_err <= 1'b0;
    end else if (clear_stats) begin
      r_flag_err <= 1'b0;
    end else if (w_eval && w_malformed) begin
      r_flag_err <= 1'b1;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_branch_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (w_eval),
    .i_clr   (clear_stats),
    .o_count (branch_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_taken_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (w_eval && w_cond),
    .i_clr   (clear_stats),
    .o_count (taken_count)
  );

  assign in_ready       = (r_state == ST_IDLE);
  assign resolved_valid = r_resolved;
  assign taken          = r_taken;
  assign redirect_valid = r_redir_valid;
  assign redirect_pc    = r_redir_pc;
  assign flag_err       = r_flag_err;

endmodule
